// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM states and the request legality rule.
package dmem_pkg;

    localparam int DW = 32;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_DATA = 3'd2,
        ST_WR   = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5,
        RESP    = 3'd6
    } dmem_state_t;

    // Reserved size or an address that is not naturally aligned for the size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offset[0];
            SZ_W:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit SRAM word and right-aligned core data:
// load extract with sign/zero extension, and sub-word merge for stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  lane_b_s;
    logic [15:0] lane_h_s;

    assign lane_b_s = dout[{offset, 3'b000} +: 8];
    assign lane_h_s = offset[1] ? dout[31:16] : dout[15:0];

    // Extract/extend the addressed lane and build the read-modify-write word.
    always_comb begin
        rdata  = 32'd0;
        merged = dout;
        case (size)
            SZ_B: begin
                rdata = {{24{sign_ext & lane_b_s[7]}}, lane_b_s};
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                rdata = {{16{sign_ext & lane_h_s[15]}}, lane_h_s};
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            SZ_W: begin
                rdata  = dout;
                merged = wdata;
            end
            default: begin
                rdata  = 32'd0;
                merged = dout;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller for a word-addressed synchronous SRAM without byte
// enables: one access at a time, sub-word stores done as read-modify-write.
module dmem_ctrl #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          memclk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW+1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_cs,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    import dmem_pkg::*;

    if (DW != 32) begin : g_dw_check
        $error("dmem_ctrl: only DW=32 is supported");
    end

    dmem_state_t   state_r;
    dmem_state_t   state_next_s;

    logic          we_r;
    logic [1:0]    size_r;
    logic          signed_r;
    logic [AW+1:0] addr_r;
    logic [DW-1:0] wdata_r;

    logic          rsp_valid_r;
    logic          rsp_err_r;
    logic [DW-1:0] rsp_rdata_r;

    logic [DW-1:0] ld_data_s;
    logic [DW-1:0] merged_s;

    dmem_lane_align u_align (
        .dout     (mem_dout),
        .wdata    (wdata_r),
        .offset   (addr_r[1:0]),
        .size     (size_r),
        .sign_ext (signed_r),
        .rdata    (ld_data_s),
        .merged   (merged_s)
    );

    // State register.
    always_ff @(posedge memclk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: classify the request at the handshake, then walk the access.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req_valid) begin
                    state_next_s = IDLE;
                end else if (req_bad(req_size, req_addr[1:0])) begin
                    state_next_s = RESP;
                end else if (!req_we) begin
                    state_next_s = LD_RD;
                end else if (req_size == SZ_W) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = RMW_RD;
                end
            end
            LD_RD:   state_next_s = LD_DATA;
            LD_DATA: state_next_s = RESP;
            ST_WR:   state_next_s = RESP;
            RMW_RD:  state_next_s = RMW_WR;
            RMW_WR:  state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Request latch; nothing from the core is sampled after the handshake.
    always_ff @(posedge memclk) begin
        if (rst) begin
            we_r     <= 1'b0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
        end else if (state_r == IDLE && req_valid) begin
            we_r     <= req_we;
            size_r   <= req_size;
            signed_r <= req_signed;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
        end
    end

    // SRAM controls and ready are decoded from state; reset masks them so an
    // in-flight write is dropped.
    always_comb begin
        req_ready = 1'b0;
        mem_cs    = 1'b0;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_din   = '0;
        if (rst) begin
            req_ready = 1'b0;
        end else begin
            req_ready = (state_r == IDLE);
            mem_raddr = addr_r[AW+1:2];
            mem_waddr = addr_r[AW+1:2];
            case (state_r)
                LD_RD, RMW_RD: begin
                    mem_cs   = 1'b1;
                    mem_rden = 1'b1;
                end
                ST_WR: begin
                    mem_cs   = 1'b1;
                    mem_wren = 1'b1;
                    mem_din  = wdata_r;
                end
                RMW_WR: begin
                    mem_cs   = 1'b1;
                    mem_wren = 1'b1;
                    mem_din  = merged_s;
                end
                default: begin
                    mem_cs = 1'b0;
                end
            endcase
        end
    end

    // Response registers are loaded on entry to RESP, so they are valid during RESP.
    always_ff @(posedge memclk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= (state_next_s == RESP);
            rsp_err_r   <= (state_r == IDLE) && (state_next_s == RESP);
            rsp_rdata_r <= (state_r == LD_DATA) ? ld_data_s : '0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: SRAM model, word-level reference model
// with per-cycle compare, directed scenarios and randomized traffic.
module tb_dmem_ctrl;

    import dmem_pkg::*;

    localparam int AW = 8;

    logic          memclk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_cs;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
    logic          mem_init;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int hs_cyc = 0;

    always #5 memclk = ~memclk;

    dmem_ctrl #(.AW(AW), .DW(32)) dut (
        .memclk(memclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_cs(mem_cs), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    logic [31:0] sram    [0:255];
    logic [31:0] ref_mem [0:255];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    always @(posedge memclk) begin
        cyc <= cyc + 1;
    end

    // Synchronous SRAM: registered read data, write only when read is off.
    always @(posedge memclk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
        end else begin
            if (mem_cs && mem_rden) mem_dout <= sram[mem_raddr];
            if (mem_cs && mem_wren && !mem_rden) sram[mem_waddr] <= mem_din;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    // Reference model of one access, computed on the whole word.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] off);
        logic [31:0] v;
        v = w >> (8 * off);
        if (sz == 2'd0) begin
            v = v & 32'h000000FF;
            if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v & 32'h0000FFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] mask;
        if (sz == 2'd2) return wd;
        mask = (sz == 2'd0 ? 32'hFF : 32'hFFFF) << (8 * off);
        return (w & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
        logic        we;
        logic [1:0]  size;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t expq[$];
    int   busy_until = -1;

    // Compare process: checks every cycle against the reference model.
    initial begin
        exp_t e;
        logic exp_now;
        logic bad;
        int   lat;
        forever begin
            @(negedge memclk);
            if (mem_init) begin
                for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            end
            if (rst) begin
                chk("ready_in_rst", {31'd0, req_ready}, 32'd0);
                chk("mem_ctl_in_rst", {29'd0, mem_cs, mem_rden, mem_wren}, 32'd0);
                expq.delete();
                busy_until = cyc;
            end else begin
                chk("req_ready", {31'd0, req_ready}, {31'd0, cyc > busy_until});
                exp_now = (expq.size() > 0) && (expq[0].due == cyc);
                chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_now});
                if (exp_now) begin
                    e = expq.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    if (!e.err && e.we)
                        ref_mem[e.addr[9:2]] = model_store(ref_mem[e.addr[9:2]], e.size,
                                                           e.addr[1:0], e.wdata);
                end
                if (expq.size() > 0 && expq[0].err)
                    chk("err_no_cs", {31'd0, mem_cs}, 32'd0);
                if (req_valid && req_ready) begin
                    bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                          (req_size == 2'd2 && req_addr[1:0] != 2'd0);
                    lat = bad ? 1 : (!req_we ? 3 : (req_size == 2'd2 ? 2 : 3));
                    e.due   = cyc + lat;
                    e.err   = bad;
                    e.we    = req_we;
                    e.size  = req_size;
                    e.addr  = req_addr;
                    e.wdata = req_wdata;
                    e.rdata = (bad || req_we) ? 32'd0 :
                              model_load(ref_mem[req_addr[9:2]], req_size, req_signed, req_addr[1:0]);
                    expq.push_back(e);
                    busy_until = cyc + lat;
                end
            end
            chk("rden_wren_excl", {31'd0, mem_rden & mem_wren}, 32'd0);
            if (!mem_cs) chk("en_without_cs", {31'd0, mem_rden | mem_wren}, 32'd0);
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [9:0] a, input logic [31:0] wd);
        logic ok;
        @(posedge memclk);
        #1;
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge memclk);
            if (req_ready && !rst) begin
                ok = 1'b1;
                hs_cyc = cyc;
                break;
            end
        end
        chk("handshake", {31'd0, ok}, 32'd1);
        @(posedge memclk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic err, output logic [31:0] rd);
        logic got;
        got = 1'b0; lat = -1; err = 1'bx; rd = 32'hx;
        for (int i = 0; i < 12; i++) begin
            @(negedge memclk);
            if (rsp_valid) begin
                got = 1'b1; lat = cyc - hs_cyc; err = rsp_err; rd = rsp_rdata;
                break;
            end
        end
        chk("rsp_arrived", {31'd0, got}, 32'd1);
    endtask

    task automatic op(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [9:0] a, input logic [31:0] wd,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        logic err;
        logic [31:0] rd;
        issue(we, sz, sg, a, wd);
        wait_rsp(lat, err, rd);
        chk("lit_latency", lat, exp_lat);
        chk("lit_err", {31'd0, err}, {31'd0, exp_err});
        chk("lit_rdata", rd, exp_rd);
    endtask

    initial begin
        int          hs[4];
        logic [31:0] snap0, snap1, snap2;
        int          mism;
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [1:0]  rsz;
        logic [9:0]  ra;

        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = 32'd0;
        repeat (3) @(posedge memclk);
        #1;
        rst = 1'b0; mem_init = 1'b0;
        @(negedge memclk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);

        // Word store then word load.
        op(1'b1, SZ_W, 1'b0, 10'h010, 32'hDEADBEEF, 2, 1'b0, 32'd0);
        chk("sram_w4_word", sram[4], 32'hDEADBEEF);
        op(1'b0, SZ_W, 1'b0, 10'h010, 32'd0, 3, 1'b0, 32'hDEADBEEF);

        // Byte RMW store and byte loads.
        op(1'b1, SZ_W, 1'b0, 10'h010, 32'h11223344, 2, 1'b0, 32'd0);
        op(1'b1, SZ_B, 1'b0, 10'h013, 32'h000000A5, 3, 1'b0, 32'd0);
        chk("sram_w4_byte", sram[4], 32'hA5223344);
        chk("model_w4_byte", ref_mem[4], 32'hA5223344);
        op(1'b0, SZ_B, 1'b1, 10'h013, 32'd0, 3, 1'b0, 32'hFFFFFFA5);
        op(1'b0, SZ_B, 1'b0, 10'h013, 32'd0, 3, 1'b0, 32'h000000A5);

        // Half RMW store and half loads.
        op(1'b1, SZ_W, 1'b0, 10'h020, 32'hCAFEBABE, 2, 1'b0, 32'd0);
        op(1'b1, SZ_H, 1'b0, 10'h022, 32'h00008001, 3, 1'b0, 32'd0);
        chk("sram_w8_half", sram[8], 32'h8001BABE);
        op(1'b0, SZ_H, 1'b1, 10'h022, 32'd0, 3, 1'b0, 32'hFFFF8001);
        op(1'b0, SZ_H, 1'b0, 10'h020, 32'd0, 3, 1'b0, 32'h0000BABE);

        // Misaligned and reserved-size requests.
        snap0 = sram[1]; snap1 = sram[2];
        op(1'b0, SZ_W,   1'b0, 10'h005, 32'd0,        1, 1'b1, 32'd0);
        op(1'b1, SZ_H,   1'b0, 10'h007, 32'h00001234, 1, 1'b1, 32'd0);
        op(1'b1, SZ_RSV, 1'b0, 10'h008, 32'h55555555, 1, 1'b1, 32'd0);
        chk("err_mem_w1", sram[1], snap0);
        chk("err_mem_w2", sram[2], snap1);

        // Back-to-back with valid held high.
        @(posedge memclk);
        #1;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic ok;
            case (k)
                0: begin req_we = 1'b1; req_size = SZ_W;   req_addr = 10'h030; req_wdata = 32'h01020304; end
                1: begin req_we = 1'b0; req_size = SZ_W;   req_addr = 10'h030; req_wdata = 32'd0; end
                2: begin req_we = 1'b1; req_size = SZ_B;   req_addr = 10'h031; req_wdata = 32'h000000EE; end
                default: begin req_we = 1'b0; req_size = SZ_RSV; req_addr = 10'h031; req_wdata = 32'd0; end
            endcase
            ok = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge memclk);
                if (req_ready) begin ok = 1'b1; hs[k] = cyc; break; end
            end
            chk("b2b_handshake", {31'd0, ok}, 32'd1);
            @(posedge memclk);
            #1;
        end
        req_valid = 1'b0;
        chk("b2b_gap0", hs[1] - hs[0], 3);
        chk("b2b_gap1", hs[2] - hs[1], 4);
        chk("b2b_gap2", hs[3] - hs[2], 4);
        repeat (3) @(posedge memclk);
        chk("b2b_w12", sram[12], 32'h0102EE04);

        // Reset during RMW_WR of a byte store drops the write and the response.
        snap2 = sram[6];
        issue(1'b1, SZ_B, 1'b0, 10'h018, 32'h00000077);
        @(posedge memclk);
        #1;
        rst = 1'b1;
        @(posedge memclk);
        #1;
        rst = 1'b0;
        @(negedge memclk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_err", {31'd0, rsp_err}, 32'd0);
        chk("post_rst_rdata", rsp_rdata, 32'd0);
        repeat (3) @(negedge memclk);
        chk("post_rst_valid_later", {31'd0, rsp_valid}, 32'd0);
        chk("rst_no_write", sram[6], snap2);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 400; n++) begin
            rsz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra  = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
            issue(1'($urandom), rsz, 1'($urandom), ra, $urandom);
            wait_rsp(lat, err, rd);
            repeat ($urandom_range(0, 2)) @(posedge memclk);
        end

        repeat (4) @(posedge memclk);
        mism = 0;
        for (int i = 0; i < 256; i++) if (sram[i] !== ref_mem[i]) mism++;
        chk("sram_vs_model", mism, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
